// File: rtl/led_fade_seq_pkg.sv
// led_fade_pkg: shared states and constants for the LED fade sequencer
package led_fade_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, WRITE, DONE} state_t;
    localparam int NUM_CH = 3;
    localparam logic [1:0] CH_INVALID = 2'd3;
    localparam int DUTY_W = 8;
endpackage

// File: rtl/led_fade_seq_duty_step.sv
// duty_step: moves one duty byte one count toward its target
module duty_step
    import led_fade_pkg::*;
(
    input  logic [DUTY_W-1:0] cur,
    input  logic [DUTY_W-1:0] tgt,
    output logic [DUTY_W-1:0] nxt,
    output logic              eq
);
    assign eq  = cur == tgt;
    assign nxt = cur < tgt ? cur + 8'd1 : cur > tgt ? cur - 8'd1 : cur;
endmodule

// File: rtl/led_fade_seq.sv
// led_fade_seq: fade sequencer and host-priority bus arbiter for the LED PWM registers
module led_fade_seq
    import led_fade_pkg::*;
#(
    parameter int RATE_W = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              CmdValid,
    output logic              CmdReady,
    input  logic [1:0]        CmdChan,
    input  logic [15:0]       CmdTarget,
    input  logic [RATE_W-1:0] CmdRate,
    input  logic              Abort,
    input  logic [2:0]        HostAddr,
    input  logic [15:0]       HostDataWr,
    input  logic              HostEn,
    input  logic              HostRd,
    input  logic              HostWr,
    output logic [2:0]        Addr,
    output logic [15:0]       DataWr,
    output logic              En,
    output logic              Rd,
    output logic              Wr,
    output logic              Busy,
    output logic              Done
);
    localparam logic [RATE_W-1:0] ONE = RATE_W'(1);

    state_t state, state_nxt;
    logic [15:0] sh [NUM_CH];
    logic [1:0] chan, cur_ch;
    logic [15:0] target, cur, tgt, nxt;
    logic [RATE_W-1:0] rate, cnt, rate_eff;
    logic eq_g, eq_r, host_wr, seq_wr;

    // In IDLE the step unit compares against the incoming command, otherwise against the latched fade
    assign cur_ch   = state == IDLE ? CmdChan : chan;
    assign tgt      = state == IDLE ? CmdTarget : target;
    assign cur      = cur_ch == 2'd0 ? sh[0] : cur_ch == 2'd1 ? sh[1] : cur_ch == 2'd2 ? sh[2] : '0;
    assign rate_eff = CmdRate == '0 ? ONE : CmdRate;
    assign host_wr  = HostEn & HostWr & (HostAddr < 3'(NUM_CH));

    duty_step u_green (.cur(cur[15:8]), .tgt(tgt[15:8]), .nxt(nxt[15:8]), .eq(eq_g));
    duty_step u_red   (.cur(cur[7:0]),  .tgt(tgt[7:0]),  .nxt(nxt[7:0]),  .eq(eq_r));

    // State register
    always_ff @(posedge Clk)
        state <= Reset ? IDLE : state_nxt;

    // Next state; Abort overrides everything outside IDLE
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (CmdValid) state_nxt = (CmdChan == CH_INVALID || (eq_g && eq_r)) ? DONE : WAIT;
            WAIT:  if (cnt == ONE) state_nxt = WRITE;
            WRITE: if (!HostEn) state_nxt = nxt == target ? DONE : WAIT;
            DONE:  state_nxt = IDLE;
        endcase
        if (state != IDLE && Abort) state_nxt = IDLE;
    end

    // Outputs and bus mux; the host always wins the bus
    always_comb begin
        seq_wr   = state == WRITE && !HostEn && !Abort && !Reset;
        CmdReady = state == IDLE;
        Busy     = state != IDLE;
        Done     = state == DONE && !Abort && !Reset;
        Addr     = HostEn ? HostAddr : {1'b0, chan};
        DataWr   = HostEn ? HostDataWr : nxt;
        En       = HostEn ? 1'b1 : seq_wr;
        Rd       = HostEn & HostRd;
        Wr       = HostEn ? HostWr : seq_wr;
    end

    // Shadow snooping, command latch and step counter
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_CH; i++) sh[i] <= '0;
            cnt    <= '0;
            rate   <= '0;
            chan   <= '0;
            target <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                if (host_wr && HostAddr == 3'(i)) sh[i] <= HostDataWr;
                else if (seq_wr && chan == 2'(i)) sh[i] <= nxt;
            if (state == IDLE && CmdValid) begin
                chan   <= CmdChan;
                target <= CmdTarget;
                rate   <= rate_eff;
                cnt    <= rate_eff;
            end else if (state == WAIT) cnt <= cnt - ONE;
            else if (seq_wr) cnt <= rate;
        end
    end
endmodule

// File: tb/tb_led_fade_seq.sv
// tb_led_fade_seq: randomized and directed checks of led_fade_seq against a timestamp-based fade model
module tb_led_fade_seq;
    localparam int RW = 8;

    logic Clk = 0, Reset = 1, CmdValid = 0, Abort = 0, HostEn = 0, HostRd = 0, HostWr = 0;
    logic [1:0] CmdChan = 0;
    logic [15:0] CmdTarget = 0, HostDataWr = 0;
    logic [RW-1:0] CmdRate = 0;
    logic [2:0] HostAddr = 0;
    logic CmdReady, En, Rd, Wr, Busy, Done;
    logic [2:0] Addr;
    logic [15:0] DataWr;

    led_fade_seq #(.RATE_W(RW)) dut (
        .Clk(Clk), .Reset(Reset), .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdChan(CmdChan),
        .CmdTarget(CmdTarget), .CmdRate(CmdRate), .Abort(Abort), .HostAddr(HostAddr),
        .HostDataWr(HostDataWr), .HostEn(HostEn), .HostRd(HostRd), .HostWr(HostWr),
        .Addr(Addr), .DataWr(DataWr), .En(En), .Rd(Rd), .Wr(Wr), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    int errors = 0, checks = 0, cyc = 0;

    // Model: a fade is active with a due cycle for its next write; a Done is pending for one cycle
    logic [15:0] m_sh [3] = '{16'h0, 16'h0, 16'h0};
    bit m_act = 0, m_pd = 0;
    int m_due = 0, m_rate = 0;
    logic [1:0] m_ch = 0;
    logic [15:0] m_tgt = 0;

    typedef struct {int c; logic [2:0] a; logic [15:0] d;} wr_t;
    wr_t wr_q[$];
    int done_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] step(input logic [15:0] s, input logic [15:0] t);
        int g = s[15:8], r = s[7:0], tg = t[15:8], tr = t[7:0];
        if (g < tg) g++; else if (g > tg) g--;
        if (r < tr) r++; else if (r > tr) r--;
        return {8'(g), 8'(r)};
    endfunction

    function automatic int eff(input int r);
        return r == 0 ? 1 : r;
    endfunction

    // Compare against the model every cycle, log sequencer writes and Done, then advance the model
    always @(negedge Clk) begin
        bit busy, gate, e_wr, e_done;
        logic [15:0] nx;
        busy   = m_act | m_pd;
        gate   = Abort | Reset;
        nx     = m_act ? step(m_sh[m_ch], m_tgt) : 16'h0;
        e_wr   = m_act && cyc >= m_due && !HostEn && !gate;
        e_done = m_pd && !gate;
        chk("CmdReady", 32'(CmdReady), 32'(!busy));
        chk("Busy", 32'(Busy), 32'(busy));
        chk("Done", 32'(Done), 32'(e_done));
        chk("En", 32'(En), 32'(HostEn ? 1'b1 : e_wr));
        chk("Rd", 32'(Rd), 32'(HostEn & HostRd));
        chk("Wr", 32'(Wr), 32'(HostEn ? HostWr : e_wr));
        if (HostEn || e_wr) begin
            chk("Addr", 32'(Addr), 32'(HostEn ? HostAddr : {1'b0, m_ch}));
            chk("DataWr", 32'(DataWr), 32'(HostEn ? HostDataWr : nx));
        end
        if (En && Wr && !HostEn) wr_q.push_back('{cyc, Addr, DataWr});
        if (Done) done_q.push_back(cyc);
        if (Reset) begin
            m_act = 0;
            m_pd = 0;
            for (int i = 0; i < 3; i++) m_sh[i] = 16'h0;
        end else begin
            if (busy && Abort) begin
                m_act = 0;
                m_pd = 0;
            end else begin
                m_pd = 0;
                if (e_wr) begin
                    m_sh[m_ch] = nx;
                    if (nx == m_tgt) begin
                        m_act = 0;
                        m_pd = 1;
                    end else m_due = cyc + eff(m_rate) + 1;
                end
                if (!busy && CmdValid) begin
                    m_ch = CmdChan;
                    m_tgt = CmdTarget;
                    m_rate = int'(CmdRate);
                    if (CmdChan == 2'd3 || m_sh[CmdChan] == CmdTarget) m_pd = 1;
                    else begin
                        m_act = 1;
                        m_due = cyc + eff(m_rate) + 1;
                    end
                end
            end
            if (HostEn && HostWr && HostAddr < 3'd3) m_sh[HostAddr[1:0]] = HostDataWr;
        end
        cyc++;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic cmd(input logic [1:0] ch, input logic [15:0] t, input int r, output int a);
        CmdValid = 1;
        CmdChan = ch;
        CmdTarget = t;
        CmdRate = RW'(r);
        a = cyc;
        tick();
        CmdValid = 0;
    endtask

    task automatic hwrite(input logic [2:0] ad, input logic [15:0] d);
        HostEn = 1;
        HostWr = 1;
        HostAddr = ad;
        HostDataWr = d;
        tick();
        HostEn = 0;
        HostWr = 0;
    endtask

    task automatic clr();
        wr_q.delete();
        done_q.delete();
    endtask

    initial begin
        int a;
        tick(3);
        Reset = 0;
        tick();
        chk("rst_ready", 32'(CmdReady), 1);
        chk("rst_busy", 32'(Busy), 0);

        clr();
        cmd(2'd0, 16'h0302, 2, a);
        tick(14);
        chk("t1_nwr", wr_q.size(), 3);
        if (wr_q.size() == 3) begin
            chk("t1_d0", 32'(wr_q[0].d), 32'h0101);
            chk("t1_d1", 32'(wr_q[1].d), 32'h0202);
            chk("t1_d2", 32'(wr_q[2].d), 32'h0302);
            chk("t1_a0", 32'(wr_q[0].a), 0);
            chk("t1_c0", wr_q[0].c - a, 3);
            chk("t1_c1", wr_q[1].c - a, 6);
            chk("t1_c2", wr_q[2].c - a, 9);
        end
        chk("t1_ndone", done_q.size(), 1);
        if (done_q.size() == 1) chk("t1_done_at", done_q[0] - a, 10);
        chk("t1_busy_end", 32'(Busy), 0);
        chk("t1_model_sh0", 32'(m_sh[0]), 32'h0302);

        clr();
        cmd(2'd1, 16'h0000, 3, a);
        tick(4);
        chk("t2_nwr", wr_q.size(), 0);
        chk("t2_ndone", done_q.size(), 1);
        if (done_q.size() == 1) chk("t2_done_at", done_q[0] - a, 1);

        clr();
        cmd(2'd3, 16'h1234, 5, a);
        tick(3);
        chk("t3_nwr", wr_q.size(), 0);
        chk("t3_ndone", done_q.size(), 1);
        if (done_q.size() == 1) chk("t3_done_at", done_q[0] - a, 1);

        for (int r = 0; r < 2; r++) begin
            clr();
            cmd(2'd2, r == 0 ? 16'h0001 : 16'h0000, r, a);
            tick(5);
            chk("r01_nwr", wr_q.size(), 1);
            if (wr_q.size() == 1) begin
                chk("r01_c", wr_q[0].c - a, 2);
                chk("r01_a", 32'(wr_q[0].a), 2);
                chk("r01_d", 32'(wr_q[0].d), r == 0 ? 32'h0001 : 32'h0000);
            end
            if (done_q.size() == 1) chk("r01_done_at", done_q[0] - a, 3);
        end

        clr();
        cmd(2'd0, 16'h0300, 1, a);
        tick();
        HostEn = 1;
        HostRd = 1;
        HostAddr = 3'd5;
        tick(4);
        HostEn = 0;
        HostRd = 0;
        tick(6);
        chk("t4_nwr", wr_q.size(), 2);
        if (wr_q.size() == 2) begin
            chk("t4_c0", wr_q[0].c - a, 6);
            chk("t4_d0", 32'(wr_q[0].d), 32'h0301);
            chk("t4_c1", wr_q[1].c - a, 8);
            chk("t4_d1", 32'(wr_q[1].d), 32'h0300);
        end
        if (done_q.size() == 1) chk("t4_done_at", done_q[0] - a, 9);

        hwrite(3'd2, 16'h0303);
        clr();
        cmd(2'd2, 16'h0000, 3, a);
        hwrite(3'd2, 16'h0505);
        tick(25);
        chk("t5_nwr", wr_q.size(), 5);
        if (wr_q.size() == 5) begin
            chk("t5_d0", 32'(wr_q[0].d), 32'h0404);
            chk("t5_c0", wr_q[0].c - a, 4);
            chk("t5_d4", 32'(wr_q[4].d), 32'h0000);
        end
        chk("t5_ndone", done_q.size(), 1);
        if (done_q.size() == 1) chk("t5_done_at", done_q[0] - a, 21);

        clr();
        cmd(2'd0, 16'h0310, 4, a);
        tick();
        Abort = 1;
        tick();
        Abort = 0;
        chk("t6_ready", 32'(CmdReady), 1);
        chk("t6_busy", 32'(Busy), 0);
        tick(10);
        chk("t6_nwr", wr_q.size(), 0);
        chk("t6_ndone", done_q.size(), 0);

        clr();
        cmd(2'd1, 16'h0505, 1, a);
        tick();
        Reset = 1;
        tick();
        Reset = 0;
        chk("t7_ready", 32'(CmdReady), 1);
        chk("t7_busy", 32'(Busy), 0);
        tick(3);
        chk("t7_nwr", wr_q.size(), 0);
        chk("t7_ndone", done_q.size(), 0);
        clr();
        cmd(2'd0, 16'h0101, 1, a);
        tick(5);
        chk("t7b_nwr", wr_q.size(), 1);
        if (wr_q.size() == 1) chk("t7b_d", 32'(wr_q[0].d), 32'h0101);

        repeat (3000) begin
            CmdValid = $urandom_range(0, 9) < 3;
            CmdChan = 2'($urandom_range(0, 3));
            CmdTarget = {8'($urandom_range(0, 5)), 8'($urandom_range(0, 5))};
            CmdRate = RW'($urandom_range(0, 3));
            Abort = $urandom_range(0, 49) == 0;
            HostEn = $urandom_range(0, 9) < 2;
            HostRd = 1'($urandom_range(0, 1));
            HostWr = 1'($urandom_range(0, 1));
            HostAddr = 3'($urandom_range(0, 3));
            HostDataWr = {8'($urandom_range(0, 5)), 8'($urandom_range(0, 5))};
            Reset = $urandom_range(0, 299) == 0;
            tick();
        end
        {CmdValid, Abort, HostEn, HostRd, HostWr, Reset} = '0;
        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
